decode_stage: RTL and testbench

Instruction-decode / register-read stage of the 8-bit lab CPU, directly upstream of the ALU. Holds the 4×8 register file, decodes each 8-bit instruction into the ALU's operand and control inputs (readdata1, readdata2, sign_extended, alusrc), and registers them in a one-entry output register with a valid/ready handshake. Also accepts the writeback port from the stage after the ALU, with same-cycle write-to-read bypass.

---
 rtl/decode_stage.sv | 126 ++++++++++++
 tb/tb_decode_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode / register-read stage with 4x8 register file
//
// Decodes one 8-bit instruction per accept into ALU operands and controls,
// held in a one-entry output register behind a valid/ready handshake.
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   instr, in_valid, in_ready  upstream instruction handshake
//   wb_en, wb_addr, wb_data    writeback port into the register file
//   out_valid, out_ready       downstream handshake toward the ALU
//   readdata1, readdata2       captured R[rs], R[rt]
//   sign_extended, alusrc      captured immediate and B-operand select
//   regwrite, wr_addr, jump    captured writeback / control fields
module decode_stage (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       wb_en,
    input  logic [1:0] wb_addr,
    input  logic [7:0] wb_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] readdata1,
    output logic [7:0] readdata2,
    output logic [7:0] sign_extended,
    output logic       alusrc,
    output logic       regwrite,
    output logic [1:0] wr_addr,
    output logic       jump
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_OUT  = 2'b10;
    localparam logic [1:0] OP_JMP  = 2'b11;

    logic [7:0] regs [0:3];

    logic [1:0] opcode;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [7:0] rd1_next;
    logic [7:0] rd2_next;
    logic [7:0] sext_next;
    logic       alusrc_next;
    logic       regwrite_next;
    logic [1:0] wr_addr_next;
    logic       jump_next;
    logic       accept;

    assign opcode   = instr[7:6];
    assign rs       = instr[5:4];
    assign rt       = instr[3:2];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Same-cycle writeback is forwarded so the captured operand is never stale.
    assign rd1_next = (wb_en && (wb_addr == rs)) ? wb_data : regs[rs];
    assign rd2_next = (wb_en && (wb_addr == rt)) ? wb_data : regs[rt];

    always_comb begin
        sext_next     = {{6{instr[1]}}, instr[1:0]};
        alusrc_next   = 1'b0;
        regwrite_next = 1'b0;
        wr_addr_next  = 2'b00;
        jump_next     = 1'b0;
        case (opcode)
            OP_ADD: begin
                regwrite_next = 1'b1;
                wr_addr_next  = instr[1:0];
            end
            OP_ADDI: begin
                regwrite_next = 1'b1;
                wr_addr_next  = rt;
                alusrc_next   = 1'b1;
            end
            OP_OUT: begin
            end
            OP_JMP: begin
                alusrc_next = 1'b1;
                jump_next   = 1'b1;
                sext_next   = {{2{instr[5]}}, instr[5:0]};
            end
            default: begin
            end
        endcase
    end

    // Writeback commits regardless of the output handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            readdata1     <= 8'h00;
            readdata2     <= 8'h00;
            sign_extended <= 8'h00;
            alusrc        <= 1'b0;
            regwrite      <= 1'b0;
            wr_addr       <= 2'b00;
            jump          <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            readdata1     <= rd1_next;
            readdata2     <= rd2_next;
            sign_extended <= sext_next;
            alusrc        <= alusrc_next;
            regwrite      <= regwrite_next;
            wr_addr       <= wr_addr_next;
            jump          <= jump_next;
        end else if (out_ready) begin
            // Drain only; data fields keep their last values.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instr;
    logic       in_valid;
    logic       in_ready;
    logic       wb_en;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] readdata1;
    logic [7:0] readdata2;
    logic [7:0] sign_extended;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] wr_addr;
    logic       jump;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid),
        .in_ready(in_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .readdata1(readdata1),
        .readdata2(readdata2), .sign_extended(sign_extended), .alusrc(alusrc),
        .regwrite(regwrite), .wr_addr(wr_addr), .jump(jump)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fields(input string tag, input logic [7:0] r1, input logic [7:0] r2,
                                input logic [7:0] se, input logic as, input logic rw,
                                input logic [1:0] wa, input logic jp);
        check({tag, ".valid"}, {7'd0, out_valid}, 8'd1);
        check({tag, ".rd1"}, readdata1, r1);
        check({tag, ".rd2"}, readdata2, r2);
        check({tag, ".sext"}, sign_extended, se);
        check({tag, ".alusrc"}, {7'd0, alusrc}, {7'd0, as});
        check({tag, ".regwrite"}, {7'd0, regwrite}, {7'd0, rw});
        check({tag, ".wr_addr"}, {6'd0, wr_addr}, {6'd0, wa});
        check({tag, ".jump"}, {7'd0, jump}, {7'd0, jp});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".valid"}, {7'd0, out_valid}, 8'd0);
        check({tag, ".in_ready"}, {7'd0, in_ready}, 8'd1);
        check({tag, ".rd1"}, readdata1, 8'd0);
        check({tag, ".rd2"}, readdata2, 8'd0);
        check({tag, ".sext"}, sign_extended, 8'd0);
        check({tag, ".ctl"}, {4'd0, alusrc, regwrite, jump, 1'b0}, 8'd0);
        check({tag, ".wr_addr"}, {6'd0, wr_addr}, 8'd0);
    endtask

    initial begin
        reset = 1'b1; instr = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = 2'd0; wb_data = 8'h00;
        #2;
        check_reset_outputs("por");
        tick();
        reset = 1'b0;

        // OUT r1 after reset reads zero
        instr = 8'h90; in_valid = 1'b1;
        tick();
        check_fields("out_r1", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);

        // Writebacks, stage drains
        in_valid = 1'b0; wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'd41;
        tick();
        check("drain.valid", {7'd0, out_valid}, 8'd0);
        wb_addr = 2'd2; wb_data = 8'd12;
        tick();
        wb_en = 1'b0;

        // ADD r3,r1,r2
        instr = 8'h1B; in_valid = 1'b1;
        tick();
        check_fields("add", 8'd41, 8'd12, 8'hFF, 1'b0, 1'b1, 2'd3, 1'b0);

        // ADDI r2,r0,-1 (back-to-back accept)
        instr = 8'h4B;
        tick();
        check_fields("addi", 8'd0, 8'd12, 8'hFF, 1'b1, 1'b1, 2'd2, 1'b0);

        // JMP imm6=100000
        instr = 8'hE0;
        tick();
        check_fields("jmp", 8'd12, 8'd0, 8'hE0, 1'b1, 1'b0, 2'd0, 1'b1);

        // Bypass: wb r1=3C while accepting ADD r0,r1,r1
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h3C; instr = 8'h14;
        tick();
        check_fields("bypass", 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
        wb_en = 1'b0;

        // ADDI with positive imm2 = 01
        instr = 8'h5D;
        tick();
        check_fields("addi_pos", 8'h3C, 8'h00, 8'h01, 1'b1, 1'b1, 2'd3, 1'b0);

        // Accept while draining, then stall
        instr = 8'h1B;
        tick();
        check_fields("stall_cap", 8'h3C, 8'd12, 8'hFF, 1'b0, 1'b1, 2'd3, 1'b0);
        out_ready = 1'b0; instr = 8'h4B;
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h77;
        #1;
        check("stall.in_ready", {7'd0, in_ready}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            wb_en = 1'b0;
            check_fields("stall_hold", 8'h3C, 8'd12, 8'hFF, 1'b0, 1'b1, 2'd3, 1'b0);
            check("stall_hold.in_ready", {7'd0, in_ready}, 8'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release.in_ready", {7'd0, in_ready}, 8'd1);
        tick();
        check_fields("release", 8'd0, 8'd12, 8'hFF, 1'b1, 1'b1, 2'd2, 1'b0);
        instr = 8'h90;
        tick();
        check_fields("wb_in_stall", 8'h77, 8'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);

        // Reset mid-stall with a pending writeback
        instr = 8'h1B;
        tick();
        out_ready = 1'b0; in_valid = 1'b1; instr = 8'h4B;
        wb_en = 1'b1; wb_addr = 2'd2; wb_data = 8'hAA;
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        reset = 1'b0;
        tick();
        check("post_rst.valid", {7'd0, out_valid}, 8'd0);

        // Every register reads zero after reset
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr = {2'b10, k[1:0], k[1:0], 2'b00};
            tick();
            check($sformatf("zero_r%0d.rd1", k), readdata1, 8'd0);
            check($sformatf("zero_r%0d.rd2", k), readdata2, 8'd0);
        end
        in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
